// File: rtl/freq_meas_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | freq_meas_multi: N-channel reciprocal frequency meter, one shared divider |
// | Option macro FREQ_MEAS_FRAC_EN: result in fixed point, FRAC_W frac bits.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module freq_meas_multi #(
  parameter int          N_CH          = 4,
  parameter int unsigned F_CLK_HZ      = 50_000_000,
  parameter int          GATE_CYCLES   = 50_000_000,
  parameter int          PERIOD_CYCLES = 75_000_000,
  parameter int          CNT_W         = 27,
  parameter int          FREQ_W        = 32,
  parameter int          FRAC_W        = 8,
  localparam int         CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_CH-1:0]   test_sig,
  output logic              freq_valid,
  output logic [CH_W-1:0]   freq_ch,
  output logic [FREQ_W-1:0] freq_data,
  output logic              freq_err
);

`ifdef FREQ_MEAS_FRAC_EN
  localparam int SHIFT = FRAC_W;
`else
  localparam int SHIFT = 0 * FRAC_W;  // integer Hz: fractional width has no effect
`endif
  localparam int DIV_ITERS = CNT_W + 32 + SHIFT;
  localparam int NUM_W     = DIV_ITERS;
  localparam int IT_W      = $clog2(DIV_ITERS + 1);
  localparam int PER_W     = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  typedef enum logic [2:0] {
    CH_IDLE  = 3'd0,
    CH_ARMED = 3'd1,
    CH_COUNT = 3'd2,
    CH_DRAIN = 3'd3,
    CH_DONE  = 3'd4
  } ch_state_t;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_RUN  = 2'd1,
    DV_FIN  = 2'd2
  } div_state_t;

  // Period counter and gate
  logic [PER_W-1:0] cnt;
  logic             last;
  logic             gate;

  assign last = (cnt == PER_W'(PERIOD_CYCLES - 1));
  assign gate = (cnt < PER_W'(GATE_CYCLES));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt <= '0;
    else         cnt <= last ? '0 : cnt + 1'b1;
  end

  // Two-flop synchroniser plus a third flop for rising-edge detection
  logic [N_CH-1:0] s1, s2, s3, rise;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= test_sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  logic [CNT_W-1:0] snap_x_all  [N_CH];
  logic [CNT_W-1:0] snap_y_all  [N_CH];
  logic             snap_ok_all [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t        state, nxt;
    logic [CNT_W-1:0] x, y, snap_x, snap_y;
    logic             ovf, snap_ok;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= CH_IDLE;
      else         state <= nxt;
    end

    always_comb begin
      nxt = state;
      if (last) begin
        nxt = CH_IDLE;
      end else begin
        case (state)
          CH_IDLE:  if (cnt == '0) nxt = CH_ARMED;
          CH_ARMED: if (rise[i])   nxt = CH_COUNT;
          CH_COUNT: if (!gate)     nxt = CH_DRAIN;
          CH_DRAIN: if (rise[i])   nxt = CH_DONE;
          CH_DONE:  nxt = CH_DONE;
          default:  nxt = CH_IDLE;
        endcase
      end
    end

    // An edge in COUNT at the gate fall is counted; only DRAIN edges close
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        x       <= '0;
        y       <= '0;
        ovf     <= 1'b0;
        snap_x  <= '0;
        snap_y  <= '0;
        snap_ok <= 1'b0;
      end else begin
        if (state == CH_ARMED && rise[i]) begin
          x   <= '0;
          y   <= '0;
          ovf <= 1'b0;
        end else if (state == CH_COUNT || state == CH_DRAIN) begin
          if (y == '1) ovf <= 1'b1;
          else         y   <= y + 1'b1;
          if (rise[i]) begin
            if (x == '1) ovf <= 1'b1;
            else         x   <= x + 1'b1;
          end
        end
        if (last) begin
          snap_x  <= x;
          snap_y  <= y;
          snap_ok <= (state == CH_DONE) && !ovf && (y != '0);
        end
      end
    end

    assign snap_x_all[i]  = snap_x;
    assign snap_y_all[i]  = snap_y;
    assign snap_ok_all[i] = snap_ok;
  end

  // Lowest-index pending channel wins the divider
  logic [N_CH-1:0] pending;
  logic            sel_found;
  logic [CH_W-1:0] sel_idx;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found = 1'b1;
        sel_idx   = CH_W'(i);
      end
    end
  end

  logic [CNT_W-1:0] sel_x, sel_y;
  logic             sel_ok;

  assign sel_x  = snap_x_all[sel_idx];
  assign sel_y  = snap_y_all[sel_idx];
  assign sel_ok = snap_ok_all[sel_idx];

  div_state_t       div_state, div_next;
  logic [NUM_W-1:0] num, quo;
  logic [CNT_W-1:0] den, rem, rem_next;
  logic [CNT_W:0]   rem_sh;
  logic             rem_ge;
  logic [IT_W-1:0]  it_cnt;
  logic [CH_W-1:0]  cur_ch;

  assign rem_sh   = {rem, num[NUM_W-1]};
  assign rem_ge   = (rem_sh >= {1'b0, den});
  assign rem_next = rem_ge ? CNT_W'(rem_sh - {1'b0, den}) : rem_sh[CNT_W-1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) div_state <= DV_IDLE;
    else         div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      DV_IDLE: if (sel_found && sel_ok) div_next = DV_RUN;
      DV_RUN:  if (it_cnt == '0)        div_next = DV_FIN;
      DV_FIN:  div_next = DV_IDLE;
      default: div_next = DV_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pending    <= '0;
      num        <= '0;
      quo        <= '0;
      den        <= '0;
      rem        <= '0;
      it_cnt     <= '0;
      cur_ch     <= '0;
      freq_valid <= 1'b0;
      freq_ch    <= '0;
      freq_data  <= '0;
      freq_err   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (last)
        pending <= '1;
      else if (div_state == DV_IDLE && sel_found)
        pending[sel_idx] <= 1'b0;

      case (div_state)
        DV_IDLE: begin
          if (sel_found) begin
            cur_ch <= sel_idx;
            if (!sel_ok) begin
              freq_valid <= 1'b1;
              freq_ch    <= sel_idx;
              freq_data  <= '0;
              freq_err   <= 1'b1;
            end else begin
              num    <= (NUM_W'(sel_x) * NUM_W'(F_CLK_HZ)) << SHIFT;
              den    <= sel_y;
              rem    <= '0;
              quo    <= '0;
              it_cnt <= IT_W'(DIV_ITERS - 1);
            end
          end
        end
        DV_RUN: begin
          rem    <= rem_next;
          quo    <= {quo[NUM_W-2:0], rem_ge};
          num    <= num << 1;
          it_cnt <= it_cnt - 1'b1;
        end
        DV_FIN: begin
          freq_valid <= 1'b1;
          freq_ch    <= cur_ch;
          if ((quo >> FREQ_W) != '0) begin
            freq_data <= '1;
            freq_err  <= 1'b1;
          end else begin
            freq_data <= FREQ_W'(quo);
            freq_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meas_multi.sv
`default_nettype none
// tb_freq_meas_multi: directed vectors for freq_meas_multi (2 ch, 1 kHz ref, gate 200, period 400).
`timescale 1ns/1ps
module tb_freq_meas_multi;

  localparam int N_CH   = 2;
  localparam int F_HZ   = 1000;
  localparam int GATE   = 200;
  localparam int PERIOD = 400;
  localparam int CNT_W  = 27;
  localparam int FREQ_W = 32;
  localparam int FRAC_W = 8;
`ifdef FREQ_MEAS_FRAC_EN
  localparam int  ITERS = CNT_W + 32 + FRAC_W;
  localparam longint F10 = 25600;
  localparam longint F12 = 21333;
  localparam longint F4  = 64000;
`else
  localparam int  ITERS = CNT_W + 32;
  localparam longint F10 = 100;
  localparam longint F12 = 83;
  localparam longint F4  = 250;
`endif
  localparam int LAT = ITERS + 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [N_CH-1:0]   test_sig = '0;
  logic              freq_valid;
  logic [0:0]        freq_ch;
  logic [FREQ_W-1:0] freq_data;
  logic              freq_err;

  freq_meas_multi #(
    .N_CH(N_CH), .F_CLK_HZ(F_HZ), .GATE_CYCLES(GATE), .PERIOD_CYCLES(PERIOD),
    .CNT_W(CNT_W), .FREQ_W(FREQ_W), .FRAC_W(FRAC_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .test_sig(test_sig),
    .freq_valid(freq_valid), .freq_ch(freq_ch), .freq_data(freq_data), .freq_err(freq_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc = cyc + 1;

  // Square-wave generators; period 0 holds the channel low, reset restarts in the low phase
  int gen_per [N_CH] = '{0, 0};
  int gen_cnt [N_CH] = '{0, 0};
  always @(negedge sys_clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (sys_rst || gen_per[i] == 0) begin
        gen_cnt[i]  = gen_per[i] / 2;
        test_sig[i] = 1'b0;
      end else begin
        test_sig[i] = (gen_cnt[i] < gen_per[i] / 2);
        gen_cnt[i]  = (gen_cnt[i] + 1) % gen_per[i];
      end
    end
  end

  typedef struct { int t; int ch; longint data; bit err; } strobe_t;
  strobe_t seen[$];
  always @(negedge sys_clk)
    if (freq_valid) seen.push_back('{t: cyc, ch: int'(freq_ch), data: longint'(freq_data), err: freq_err});

  typedef struct {
    int     per0;
    int     per1;
    int     t  [2];
    int     ch [2];
    longint d  [2];
    bit     e  [2];
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int base     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int p0, input int p1, input string tag);
    @(negedge sys_clk);
    sys_rst    = 1'b1;
    gen_per[0] = p0;
    gen_per[1] = p1;
    repeat (3) @(negedge sys_clk);
    check({tag, " reset outputs"}, longint'({freq_valid, freq_ch, freq_data, freq_err}), 0);
    seen.delete();
    sys_rst = 1'b0;
    base    = cyc;
  endtask

  task automatic check_strobes(input vec_t v, input string tag);
    check({tag, " strobe count"}, seen.size(), 2);
    for (int k = 0; k < 2; k++) begin
      if (k < seen.size()) begin
        check($sformatf("%s s%0d time", tag, k), seen[k].t - base, v.t[k]);
        check($sformatf("%s s%0d ch", tag, k), seen[k].ch, v.ch[k]);
        check($sformatf("%s s%0d data", tag, k), seen[k].data, v.d[k]);
        check($sformatf("%s s%0d err", tag, k), seen[k].err, v.e[k]);
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL %s s%0d strobe: got none, expected one at cycle %0d", tag, k, v.t[k]);
      end
    end
  endtask

  vec_t vecs [5];

  initial begin
    // ok channel strobes LAT cycles after selection, a skipped one after 1 cycle
    vecs[0] = '{10,  4, '{PERIOD + LAT, PERIOD + 2*LAT},  '{0, 1}, '{F10, F4}, '{0, 0}};
    vecs[1] = '{10,  0, '{PERIOD + LAT, PERIOD + LAT + 1}, '{0, 1}, '{F10, 0},  '{0, 1}};
    vecs[2] = '{12,  4, '{PERIOD + LAT, PERIOD + 2*LAT},  '{0, 1}, '{F12, F4}, '{0, 0}};
    vecs[3] = '{300, 0, '{PERIOD + 1,   PERIOD + 2},      '{0, 1}, '{0, 0},    '{1, 1}};
    vecs[4] = '{0,   4, '{PERIOD + 1,   PERIOD + 1 + LAT}, '{0, 1}, '{0, F4},   '{1, 0}};

    for (int vi = 0; vi < 5; vi++) begin
      string tag = $sformatf("v%0d", vi);
      do_reset(vecs[vi].per0, vecs[vi].per1, tag);
      repeat (vecs[vi].t[1] + 20) @(negedge sys_clk);
      check_strobes(vecs[vi], tag);
    end

    // Reset in the middle of the ch0 divide: result dropped, next period measures afresh
    do_reset(10, 4, "rstmid pre");
    while (cyc - base < PERIOD + LAT / 2) @(negedge sys_clk);
    check("rstmid no strobe before reset", seen.size(), 0);
    do_reset(10, 4, "rstmid");
    repeat (PERIOD + 2*LAT + 20) @(negedge sys_clk);
    check_strobes(vecs[0], "rstmid");

    // Outputs hold the last result between strobes
    repeat (20) @(negedge sys_clk);
    check("hold valid", freq_valid, 0);
    check("hold ch", freq_ch, 1);
    check("hold data", freq_data, F4);
    check("hold err", freq_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/freq_meas_multi.md
FREQ_MEAS_MULTI -- requirements
Module: freq_meas_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent test-signal channels (1..16).
REQ-002 SHALL have parameter F_CLK_HZ, default 50_000_000: sys_clk frequency in Hz, the reference frequency (up to 32 bits).
REQ-003 SHALL have parameter GATE_CYCLES, default 50_000_000: nominal gate length in sys_clk cycles.
REQ-004 SHALL have parameter PERIOD_CYCLES, default 75_000_000: measurement period in sys_clk cycles; must exceed GATE_CYCLES + N_CH*(DIV_ITERS+4).
REQ-005 SHALL have parameter CNT_W, default 27: width of the per-channel edge and reference counters.
REQ-006 SHALL have parameter FREQ_W, default 32: width of the frequency result.
REQ-007 SHALL have parameter FRAC_W, default 8: fractional result bits, used only with FREQ_MEAS_FRAC_EN.
REQ-008 SHALL have port sys_clk  input  1  sole clock; every register is clocked on its rising edge.
REQ-009 SHALL have port sys_rst  input  1  reset; synchronous, active-high.
REQ-010 SHALL have port test_sig  input  N_CH  asynchronous test signals, bit i is channel i.
REQ-011 SHALL have port freq_valid  output  1  one-cycle result strobe.
REQ-012 SHALL have port freq_ch  output  clog2(N_CH) (minimum 1)  channel index of the current result.
REQ-013 SHALL have port freq_data  output  FREQ_W  measured frequency.
REQ-014 SHALL have port freq_err  output  1  result invalid: no close, counter saturation or quotient saturation.

Function
REQ-015 SHALL synchronise each test_sig bit through two flops, then detect rising edges with a third flop (edge pulse 3 cycles after the input rises).
REQ-016 SHALL guarantee edge detection only when test_sig high and low phases are each at least 2 sys_clk cycles.
REQ-017 SHALL run a period counter 0..PERIOD_CYCLES-1 that wraps to 0; gate is high for counts 0..GATE_CYCLES-1.
REQ-018 SHALL run a per-channel FSM: IDLE -> ARMED at count 0; ARMED -> COUNT on the first edge (x=0, y=0); COUNT -> DRAIN when gate falls; DRAIN -> DONE on the next edge.
REQ-019 SHALL count in COUNT and DRAIN: y increments every cycle, and x increments on each edge, including the closing edge.
REQ-020 SHALL make x and y saturate at 2^CNT_W-1 and set a sticky overflow flag.
REQ-021 SHALL, at count PERIOD_CYCLES-1, snapshot every channel (x, y, done, ovf), set all pending bits and force every FSM to IDLE.
REQ-022 SHALL use one shared restoring divider: it serves the lowest-index pending channel and computes (x*F_CLK_HZ)/y at one quotient bit per cycle.
REQ-023 SHALL define DIV_ITERS = CNT_W+32 iterations, or CNT_W+32+FRAC_W with FREQ_MEAS_FRAC_EN.
REQ-024 SHALL raise freq_valid exactly DIV_ITERS+2 cycles after a channel is selected; pending bits are served back-to-back.
REQ-025 SHALL, when not DONE, overflowed or y==0, skip the divide, assert freq_valid after 1 cycle with freq_data=0 and freq_err=1.
REQ-026 SHALL, when the quotient exceeds FREQ_W bits, output freq_data all ones with freq_err=1.
REQ-027 SHALL keep freq_data, freq_ch and freq_err stable between strobes.
REQ-028 SHALL let an edge that coincides with gate fall in COUNT count and not close the window; the window closes only on a later edge in DRAIN.

Reset
REQ-029 SHALL, while sys_rst=1, clear the period counter, synchronisers, FSMs (IDLE), counters, snapshots, pending bits, divider, freq_valid, freq_ch, freq_data and freq_err to 0.
REQ-030 SHALL, on reset mid-division, discard that result with no strobe; measurement restarts at count 0 in the first cycle after release.

Configuration
REQ-031 SHALL, with macro FREQ_MEAS_FRAC_EN defined, output freq_data as unsigned fixed point with FRAC_W fractional bits, i.e. (x*F_CLK_HZ*2^FRAC_W)/y.
REQ-032 SHALL, without FREQ_MEAS_FRAC_EN, output freq_data as integer Hz, truncated, with FRAC_W ignored.

Verification
All scenarios use N_CH=2, F_CLK_HZ=1000, GATE_CYCLES=200, PERIOD_CYCLES=400, macro undefined unless stated.
REQ-033 SHALL cover: ch0 period 10 cycles (5 high/5 low) -> freq_ch=0, freq_data=100, freq_err=0.
REQ-034 SHALL cover: ch0 period 10, ch1 period 4 -> two strobes in the same period, ch0=100 then ch1=250, DIV_ITERS+2 cycles apart.
REQ-035 SHALL cover: ch1 held low -> freq_ch=1, freq_data=0, freq_err=1, 1 cycle after selection.
REQ-036 SHALL cover: ch0 period 300 cycles (no closing edge before period end) -> freq_data=0, freq_err=1.
REQ-037 SHALL cover: FREQ_MEAS_FRAC_EN, FRAC_W=8, ch0 period 12 cycles -> freq_data=21333 (83.33 Hz x 256, truncated).
REQ-038 SHALL cover: sys_rst pulsed during the ch0 divide -> no strobe; next period ch0=100 again.
